// File: rtl/valid_pulse_gen_if.sv
// rtl/valid_pulse_gen_if.sv - control/status bundle between a burst requester and valid_pulse_gen
interface valid_pulse_gen_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] gap;
  logic             valid_out;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sent;
  logic             match;

  modport master (
    output start, abort, count, gap,
    input  valid_out, busy, done, sent, match
  );

  modport slave (
    input  start, abort, count, gap,
    output valid_out, busy, done, sent, match
  );
endinterface

// File: rtl/valid_pulse_gen.sv
// rtl/valid_pulse_gen.sv - emits a programmed burst of single-cycle valid strobes separated by idle gaps
module valid_pulse_gen #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  valid_pulse_gen_if.slave   bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] gap_q, gap_d;
  logic [WIDTH-1:0] gcnt_q, gcnt_d;
  logic [WIDTH-1:0] sent_q, sent_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             match_q, match_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    sent_d  = sent_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    match_d = match_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          cnt_d   = bus.count;
          gap_d   = bus.gap;
          match_d = 1'b0;
          if (bus.count != '0) begin
            // sent counts the pulse being entered, so it reads 1 during the first strobe
            state_d = S_PULSE;
            sent_d  = WIDTH'(1);
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = S_DONE;
            sent_d  = '0;
            done_d  = 1'b1;
            match_d = 1'b1;
          end
        end
      end

      S_PULSE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          match_d = 1'b0;
        end else if (sent_q == cnt_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          match_d = 1'b1;
        end else if (gap_q == '0) begin
          sent_d  = sent_q + WIDTH'(1);
          valid_d = 1'b1;
        end else begin
          state_d = S_GAP;
          gcnt_d  = gap_q;
        end
      end

      S_GAP: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          match_d = 1'b0;
        end else if (gcnt_q == WIDTH'(1)) begin
          state_d = S_PULSE;
          gcnt_d  = '0;
          sent_d  = sent_q + WIDTH'(1);
          valid_d = 1'b1;
        end else begin
          gcnt_d  = gcnt_q - WIDTH'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      sent_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      sent_q  <= sent_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sent      = sent_q;
  assign bus.match     = match_q;
endmodule

// File: tb/tb_valid_pulse_gen.sv
// tb/tb_valid_pulse_gen.sv - table-driven bench for valid_pulse_gen
module tb_valid_pulse_gen;
  localparam int WIDTH = 8;

  typedef struct {
    int cnt;
    int gap;
    int abort_c;
    bit sa;
    bit poke;
    int exp_n;
    int exp_done;
    int busy_end;
    int exp_sent;
    bit exp_match;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  vec_t vecs[10];

  valid_pulse_gen_if #(.WIDTH(WIDTH)) bus ();

  valid_pulse_gen #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, int'(bus.valid_out), 0);
    chk({tag, "_busy"},  int'(bus.busy), 0);
    chk({tag, "_done"},  int'(bus.done), 0);
    chk({tag, "_sent"},  int'(bus.sent), 0);
    chk({tag, "_match"}, int'(bus.match), 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int period, last, pulses, valid_err, sent_err, busy_err, done_err;
    bit exp_v;
    string tag;
    tag       = $sformatf("v%0d", idx);
    period    = v.gap + 1;
    last      = ((v.busy_end > v.exp_done) ? v.busy_end : v.exp_done) + 3;
    pulses    = 0;
    valid_err = 0;
    sent_err  = 0;
    busy_err  = 0;
    done_err  = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = v.sa;
    bus.count = WIDTH'(v.cnt);
    bus.gap   = WIDTH'(v.gap);
    @(negedge clk);
    for (int c = 1; c <= last; c++) begin
      exp_v = ((c - 1) % period == 0) && ((c - 1) / period < v.exp_n);
      if (bus.valid_out) pulses++;
      if (bus.valid_out !== exp_v) valid_err++;
      if (exp_v && bus.sent !== WIDTH'((c - 1) / period + 1)) sent_err++;
      if (bus.busy !== (c <= v.busy_end)) busy_err++;
      if (bus.done !== (c == v.exp_done)) done_err++;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (c == v.abort_c) bus.abort = 1'b1;
      if (v.poke && c == 2) begin
        bus.start = 1'b1;
        bus.count = 8'd99;
        bus.gap   = 8'd0;
      end
      if (v.poke && c == v.exp_done) begin
        bus.start = 1'b1;
        bus.abort = 1'b1;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk({tag, "_pulses"},    pulses, v.exp_n);
    chk({tag, "_valid_err"}, valid_err, 0);
    chk({tag, "_sent_err"},  sent_err, 0);
    chk({tag, "_busy_err"},  busy_err, 0);
    chk({tag, "_done_err"},  done_err, 0);
    chk({tag, "_sent"},      int'(bus.sent), v.exp_sent);
    chk({tag, "_match"},     int'(bus.match), int'(v.exp_match));
  endtask

  initial begin
    int seen;
    //          cnt  gap  abort sa poke n    done   bend   sent match
    vecs[0] = '{3,   2,   0,    0, 0,   3,   8,     7,     3,   1};
    vecs[1] = '{4,   0,   0,    0, 0,   4,   5,     4,     4,   1};
    vecs[2] = '{0,   5,   0,    0, 0,   0,   1,     0,     0,   1};
    vecs[3] = '{5,   1,   5,    0, 0,   3,   0,     5,     3,   0};
    vecs[4] = '{5,   1,   4,    0, 0,   2,   0,     4,     2,   0};
    vecs[5] = '{3,   2,   0,    0, 1,   3,   8,     7,     3,   1};
    vecs[6] = '{2,   0,   0,    1, 0,   2,   3,     2,     2,   1};
    vecs[7] = '{1,   0,   0,    0, 0,   1,   2,     1,     1,   1};
    vecs[8] = '{4,   0,   2,    0, 0,   2,   0,     2,     2,   0};
    vecs[9] = '{255, 255, 0,    0, 0,   255, 65026, 65025, 255, 1};

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.count = '0;
    bus.gap   = '0;
    rst       = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("por");
    rst = 1'b1;

    // reset held for three cycles in the middle of an active burst
    @(negedge clk);
    bus.start = 1'b1;
    bus.count = 8'd5;
    bus.gap   = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_busy", int'(bus.busy), 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("rst");
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.valid_out || bus.busy || bus.done) seen++;
      @(negedge clk);
    end
    chk("post_rst_quiet", seen, 0);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
